// File: rtl/req_frame_responder.sv
// req_frame_responder: remote-side handler for the 2-byte room/sensor request
// frame. It collects the frame from the UART receiver and validates it. When
// needed it fetches a reading over a req/ack handshake with the acquisition
// block. It then answers with a 2-byte response frame through the UART
// transmitter.
// Optional feature macro: RESP_STATUS_QUERY_EN. When it is defined, sensor code
// 11 becomes a status query that returns drop_cnt and clears it once the
// response has gone out.
module req_frame_responder #(
  parameter int CLK_FREQ         = 25_000_000,
  parameter int BYTE_TIMEOUT_CYC = 250_000,
  parameter int SENS_TIMEOUT_CYC = 25_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       sens_req,
  output logic [1:0] sens_sala,
  output logic [1:0] sens_sensor,
  input  logic       sens_ack,
  input  logic [7:0] sens_data,
  output logic       resp_done,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  // The timeouts are in cycles; CLK_FREQ is only sanity-checked.
  if (CLK_FREQ <= 0 || BYTE_TIMEOUT_CYC < 2 || SENS_TIMEOUT_CYC < 2) begin : g_param_check
    $error("req_frame_responder: invalid timing parameters");
  end

  localparam logic [31:0] BYTE_TMO_LAST = 32'(BYTE_TIMEOUT_CYC - 1);
  localparam logic [31:0] SENS_TMO_LAST = 32'(SENS_TIMEOUT_CYC - 1);
  localparam logic [3:0]  STAT_OK       = 4'hA;
  localparam logic [3:0]  STAT_ERR      = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_B2    = 3'd1,
    ST_CHECK      = 3'd2,
    ST_REQ_SENSOR = 3'd3,
    ST_SEND_B1    = 3'd4,
    ST_WAIT_TX1   = 3'd5,
    ST_SEND_B2    = 3'd6,
    ST_WAIT_TX2   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  pay_q, pay_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        resp_done_q, resp_done_d;
`ifdef RESP_STATUS_QUERY_EN
  logic        query_q, query_d;
`endif

  logic [3:0]  status_s;
  logic [7:0]  err_s;
  logic        sala_ok_s;
  logic        sensor_bad_s;
  logic        drop_inc_s;
  logic        clear_s;

  // Next-state, frame validation, response byte staging and drop accounting.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    pay_d        = pay_q;
    data_d       = data_q;
    resp_done_d  = 1'b0;
    status_s     = STAT_OK;
    drop_inc_s   = 1'b0;
`ifdef RESP_STATUS_QUERY_EN
    query_d      = query_q;
    sensor_bad_s = 1'b0;
`else
    sensor_bad_s = (hdr_q[3:2] == 2'b11);
`endif

    // Error code precedence: header nibble, sala, sensor, payload.
    sala_ok_s = (hdr_q[1:0] == 2'b01) || (hdr_q[1:0] == 2'b10);
    if (hdr_q[7:4] != 4'h0) begin
      err_s = 8'h01;
    end else if (!sala_ok_s) begin
      err_s = 8'h02;
    end else if (sensor_bad_s) begin
      err_s = 8'h03;
    end else if (pay_q != 8'h00) begin
      err_s = 8'h04;
    end else begin
      err_s = 8'h00;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          hdr_d   = rx_byte;
          state_d = ST_WAIT_B2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_B2: begin
        // A byte arriving on the expiry cycle still completes the frame.
        if (rx_valid) begin
          pay_d   = rx_byte;
          state_d = ST_CHECK;
        end else if (tmr_q == BYTE_TMO_LAST) begin
          drop_inc_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_B2;
        end
      end
      ST_CHECK: begin
`ifdef RESP_STATUS_QUERY_EN
        query_d = 1'b0;
`endif
        if (err_s != 8'h00) begin
          status_s = STAT_ERR;
          data_d   = err_s;
          state_d  = ST_SEND_B1;
        end else if (hdr_q[3:2] == 2'b00) begin
          data_d  = 8'h00;
          state_d = ST_SEND_B1;
`ifdef RESP_STATUS_QUERY_EN
        end else if (hdr_q[3:2] == 2'b11) begin
          data_d  = drop_cnt_q;
          query_d = 1'b1;
          state_d = ST_SEND_B1;
`endif
        end else begin
          state_d = ST_REQ_SENSOR;
        end
      end
      ST_REQ_SENSOR: begin
        if (sens_ack) begin
          data_d  = sens_data;
          state_d = ST_SEND_B1;
        end else if (tmr_q == SENS_TMO_LAST) begin
          status_s = STAT_ERR;
          data_d   = 8'h05;
          state_d  = ST_SEND_B1;
        end else begin
          state_d = ST_REQ_SENSOR;
        end
      end
      ST_SEND_B1: begin
        if (!tx_busy) begin
          state_d = ST_WAIT_TX1;
        end else begin
          state_d = ST_SEND_B1;
        end
      end
      ST_WAIT_TX1: begin
        if (tx_done) begin
          state_d = ST_SEND_B2;
        end else begin
          state_d = ST_WAIT_TX1;
        end
      end
      ST_SEND_B2: begin
        if (!tx_busy) begin
          state_d = ST_WAIT_TX2;
        end else begin
          state_d = ST_SEND_B2;
        end
      end
      ST_WAIT_TX2: begin
        if (tx_done) begin
          resp_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT_TX2;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared timer restarts on every state entry; it only runs where a timeout applies.
    if (state_d != state_q) begin
      tmr_d = 32'd0;
    end else if (state_q == ST_WAIT_B2 || state_q == ST_REQ_SENSOR) begin
      tmr_d = tmr_q + 32'd1;
    end else begin
      tmr_d = tmr_q;
    end

    // Stage each response byte on entry to its send state and hold it through the shift-out.
    if (state_d == ST_SEND_B1 && state_q != ST_SEND_B1) begin
      tx_data_d = {status_s, hdr_q[3:0]};
    end else if (state_d == ST_SEND_B2 && state_q != ST_SEND_B2) begin
      tx_data_d = data_q;
    end else begin
      tx_data_d = tx_data_q;
    end

    // Bytes received while a response is in progress are discarded and counted.
    if (rx_valid && state_q != ST_IDLE && state_q != ST_WAIT_B2) begin
      drop_inc_s = 1'b1;
    end else begin
      drop_inc_s = drop_inc_s;
    end

`ifdef RESP_STATUS_QUERY_EN
    clear_s = query_q && resp_done_d;
`else
    clear_s = 1'b0;
`endif

    if (clear_s) begin
      drop_cnt_d = 8'h00;
    end else if (drop_inc_s && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'h01;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmr_q       <= 32'd0;
      hdr_q       <= 8'h00;
      pay_q       <= 8'h00;
      data_q      <= 8'h00;
      tx_data_q   <= 8'h00;
      drop_cnt_q  <= 8'h00;
      resp_done_q <= 1'b0;
`ifdef RESP_STATUS_QUERY_EN
      query_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      data_q      <= data_d;
      tx_data_q   <= tx_data_d;
      drop_cnt_q  <= drop_cnt_d;
      resp_done_q <= resp_done_d;
`ifdef RESP_STATUS_QUERY_EN
      query_q     <= query_d;
`endif
    end
  end

  assign tx_start    = (state_q == ST_SEND_B1 || state_q == ST_SEND_B2) && !tx_busy;
  assign tx_data     = tx_data_q;
  assign sens_req    = (state_q == ST_REQ_SENSOR);
  assign sens_sala   = sens_req ? hdr_q[1:0] : 2'b00;
  assign sens_sensor = sens_req ? hdr_q[3:2] : 2'b00;
  assign resp_done   = resp_done_q;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_req_frame_responder.sv
// Scoreboard bench for req_frame_responder: expected response bytes are queued
// when a frame is issued and a monitor pops/compares them on every tx_start.
module tb_req_frame_responder;
  localparam int BT = 200;
  localparam int ST = 40;
`ifdef RESP_STATUS_QUERY_EN
  localparam bit QUERY_EN = 1'b1;
`else
  localparam bit QUERY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       uart_busy = 1'b0;
  logic       busy_force = 1'b0;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       sens_req;
  logic [1:0] sens_sala;
  logic [1:0] sens_sensor;
  logic       sens_ack = 1'b0;
  logic [7:0] sens_data = 8'h00;
  logic       resp_done;
  logic [7:0] drop_cnt;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         tx_len = 4;
  int         drop_model = 0;
  bit         sens_allowed = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  assign tx_busy = uart_busy | busy_force;

  req_frame_responder #(
    .CLK_FREQ(25_000_000), .BYTE_TIMEOUT_CYC(BT), .SENS_TIMEOUT_CYC(ST)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .sens_req(sens_req), .sens_sala(sens_sala), .sens_sensor(sens_sensor),
    .sens_ack(sens_ack), .sens_data(sens_data), .resp_done(resp_done),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic add_drops(input int n);
    drop_model = (drop_model + n > 255) ? 255 : drop_model + n;
  endtask

  // Reference: response bytes derived directly from the frame rules.
  function automatic void model(input logic [7:0] h, input logic [7:0] p, input bit ack,
                                input logic [7:0] sd, input int drops,
                                output logic [7:0] b1, output logic [7:0] b2,
                                output bit need_sens, output bit is_query);
    logic [3:0] status;
    logic [7:0] data;
    logic [1:0] sala;
    logic [1:0] sen;
    sala = h[1:0];
    sen = h[3:2];
    need_sens = 1'b0;
    is_query = 1'b0;
    status = 4'hE;
    if (h[7:4] != 4'h0) data = 8'h01;
    else if (sala == 2'd0 || sala == 2'd3) data = 8'h02;
    else if (sen == 2'd3 && !QUERY_EN) data = 8'h03;
    else if (p != 8'h00) data = 8'h04;
    else begin
      status = 4'hA;
      case (sen)
        2'd0: data = 8'h00;
        2'd3: begin data = 8'(drops); is_query = 1'b1; end
        default: begin
          need_sens = 1'b1;
          if (ack) data = sd;
          else begin status = 4'hE; data = 8'h05; end
        end
      endcase
    end
    b1 = {status, sen, sala};
    b2 = data;
  endfunction

  // Transmitter model: busy for tx_len cycles after each tx_start, then a tx_done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tick();
        uart_busy = 1'b1;
        repeat (tx_len) tick();
        uart_busy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end
    end
  end

  // Monitor: every transmitted byte must match the head of the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        chk("tx_start_while_busy", tx_busy, 0);
        chk("tx_start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("tx_data", tx_data, mon_exp);
        end
      end
      if (sens_req === 1'b1) chk("sens_req_allowed", sens_allowed, 1);
    end
  end

  task automatic do_frame(input logic [7:0] h, input logic [7:0] p, input int gap,
                          input int ack_dly, input logic [7:0] sd, input bit ack,
                          input int inject, input bit hold);
    logic [7:0] b1;
    logic [7:0] b2;
    bit need;
    bit q;
    int n;
    model(h, p, ack, sd, drop_model, b1, b2, need, q);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    sens_allowed = need;
    if (hold) busy_force = 1'b1;
    send_byte(h);
    repeat (gap) tick();
    send_byte(p);
    if (need) begin
      n = 0;
      while (sens_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("sens_req_seen", sens_req, 1);
      chk("sens_sala", sens_sala, h[1:0]);
      chk("sens_sensor", sens_sensor, h[3:2]);
      if (ack) begin
        repeat (ack_dly) tick();
        sens_data = sd;
        sens_ack = 1'b1;
        tick();
        sens_ack = 1'b0;
        @(negedge clk);
        chk("sens_req_low_after_ack", sens_req, 0);
        chk("tx_start_latency_sensor", tx_start, 1);
      end else begin
        n = 1;
        while (n < 3 * ST) begin
          @(negedge clk);
          if (sens_req !== 1'b1) break;
          n++;
        end
        chk("sens_timeout_cycles", n, ST);
        chk("tx_start_after_sens_timeout", tx_start, 1);
      end
    end else if (hold) begin
      n = 0;
      repeat (100) begin @(negedge clk); if (tx_start === 1'b1) n++; end
      chk("tx_start_held_off", n, 0);
      tick();
      busy_force = 1'b0;
      @(negedge clk);
      chk("tx_start_after_release", tx_start, 1);
    end else begin
      @(negedge clk);
      @(negedge clk);
      chk("tx_start_latency", tx_start, 1);
    end
    if (inject > 0) begin
      n = 0;
      while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("tx_busy_seen", tx_busy, 1);
      for (int i = 0; i < inject; i++) send_byte(8'($urandom));
      add_drops(inject);
    end
    n = 0;
    while (resp_done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("resp_done_seen", resp_done, 1);
    if (q) drop_model = 0;
    chk("drop_cnt", drop_cnt, drop_model);
    chk("busy_after_resp", busy, 0);
    chk("tx_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("resp_done_one_cycle", resp_done, 0);
    sens_allowed = 1'b0;
    tick();
  endtask

  // Watchdog: abort with a failure rather than hang.
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] h;
    logic [7:0] p;
    int inj;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_sens_req", sens_req, 0);
    chk("rst_sens_sala", sens_sala, 0);
    chk("rst_sens_sensor", sens_sensor, 0);
    chk("rst_resp_done", resp_done, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Directed frames from the frame rules.
    tx_len = 4;
    do_frame(8'h01, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);
    do_frame(8'h06, 8'h00, 0, 10, 8'h5C, 1'b1, 0, 1'b0);
    do_frame(8'h13, 8'h00, 1, 0, 8'h00, 1'b1, 0, 1'b0);
    do_frame(8'h05, 8'h7F, 0, 0, 8'h00, 1'b1, 0, 1'b0);
    do_frame(8'h09, 8'h00, 0, 0, 8'h00, 1'b0, 0, 1'b0);
    do_frame(8'h00, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);
    do_frame(8'h0F, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);
    do_frame(8'h0D, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);

    // Inter-byte timeout: exact expiry cycle, then a normal frame.
    send_byte(8'h01);
    @(negedge clk);
    repeat (BT - 1) @(negedge clk);
    chk("b2_wait_before_expiry", busy, 1);
    chk("drop_before_expiry", drop_cnt, drop_model);
    @(negedge clk);
    add_drops(1);
    chk("b2_timeout_idle", busy, 0);
    chk("drop_after_expiry", drop_cnt, drop_model);
    tick();
    do_frame(8'h02, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);
    // Byte 2 on the expiry cycle wins.
    do_frame(8'h02, 8'h00, BT - 1, 0, 8'h00, 1'b1, 0, 1'b0);

    // tx_busy held high, then bytes injected during the first byte's shift-out.
    do_frame(8'h01, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b1);
    tx_len = 20;
    do_frame(8'h0A, 8'h00, 0, 3, 8'h3C, 1'b1, 3, 1'b0);

    // Stray sens_ack while idle must be ignored.
    sens_data = 8'h77;
    sens_ack = 1'b1;
    tick();
    sens_ack = 1'b0;
    tx_len = 4;
    do_frame(8'h02, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);

    // Reset while waiting for the first byte's tx_done.
    tx_len = 30;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("tx_start_before_reset", tx_start, 1);
    repeat (3) tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_tx_start", tx_start, 0);
    chk("midreset_tx_data", tx_data, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_sens_req", sens_req, 0);
    chk("midreset_drop_cnt", drop_cnt, 0);
    chk("midreset_resp_done", resp_done, 0);
    rst = 1'b0;
    exp_q.delete();
    drop_model = 0;
    repeat (60) tick();
    chk("after_reset_idle", busy, 0);

    // Three drops, then the sensor-11 frame (status query when enabled).
    tx_len = 20;
    do_frame(8'h01, 8'h00, 0, 0, 8'h00, 1'b1, 3, 1'b0);
    tx_len = 4;
    do_frame(8'h0D, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);

    // Saturation of drop_cnt.
    tx_len = 300;
    do_frame(8'h01, 8'h00, 0, 0, 8'h00, 1'b1, 270, 1'b0);
    chk("drop_saturated", drop_cnt, 255);
    tx_len = 4;
    do_frame(8'h0E, 8'h00, 0, 0, 8'h00, 1'b1, 0, 1'b0);

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      h = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      p = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      inj = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      tx_len = (inj > 0) ? 10 : int'($urandom_range(1, 8));
      do_frame(h, p, int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
               8'($urandom), ($urandom_range(0, 9) != 0), inj, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
